// File: rtl/mem_arbiter_if.sv
// Pipeline-to-arbiter-to-memory bus bundle for the unified memory arbiter.
// The slave modport is the arbiter's view; master is the pipeline/memory side.
interface mem_arbiter_if #(
  parameter int unsigned DWIDTH     = 32,
  parameter int unsigned IWIDTH     = 32,
  parameter int unsigned AWIDTH_MEM = 32
) ();
  logic                    ma_i_ce;
  logic                    ma_i_if_req;
  logic [AWIDTH_MEM-1:0]   ma_i_if_addr;
  logic [IWIDTH-1:0]       ma_o_if_data;
  logic                    ma_o_if_ack;
  logic                    ma_i_dm_req;
  logic                    ma_i_dm_we;
  logic [AWIDTH_MEM-1:0]   ma_i_dm_addr;
  logic [DWIDTH-1:0]       ma_i_dm_wdata;
  logic [DWIDTH/8-1:0]     ma_i_dm_be;
  logic [DWIDTH-1:0]       ma_o_dm_rdata;
  logic                    ma_o_dm_ack;
  logic                    ma_o_mem_req;
  logic                    ma_o_mem_we;
  logic [AWIDTH_MEM-1:0]   ma_o_mem_addr;
  logic [DWIDTH-1:0]       ma_o_mem_wdata;
  logic [DWIDTH/8-1:0]     ma_o_mem_be;
  logic                    ma_i_mem_ack;
  logic [DWIDTH-1:0]       ma_i_mem_rdata;
  logic                    ma_o_err;
  logic                    ma_o_stall_if;
  logic                    ma_o_stall_dm;

  modport slave (
    input  ma_i_ce,
    input  ma_i_if_req, ma_i_if_addr,
    output ma_o_if_data, ma_o_if_ack,
    input  ma_i_dm_req, ma_i_dm_we, ma_i_dm_addr, ma_i_dm_wdata, ma_i_dm_be,
    output ma_o_dm_rdata, ma_o_dm_ack,
    output ma_o_mem_req, ma_o_mem_we, ma_o_mem_addr, ma_o_mem_wdata, ma_o_mem_be,
    input  ma_i_mem_ack, ma_i_mem_rdata,
    output ma_o_err, ma_o_stall_if, ma_o_stall_dm
  );

  modport master (
    output ma_i_ce,
    output ma_i_if_req, ma_i_if_addr,
    input  ma_o_if_data, ma_o_if_ack,
    output ma_i_dm_req, ma_i_dm_we, ma_i_dm_addr, ma_i_dm_wdata, ma_i_dm_be,
    input  ma_o_dm_rdata, ma_o_dm_ack,
    input  ma_o_mem_req, ma_o_mem_we, ma_o_mem_addr, ma_o_mem_wdata, ma_o_mem_be,
    output ma_i_mem_ack, ma_i_mem_rdata,
    input  ma_o_err, ma_o_stall_if, ma_o_stall_dm
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port unified memory between instruction fetch and data
// access, with starvation protection for fetch and a timeout abort for hung accesses.
module mem_arbiter #(
  parameter int unsigned DWIDTH       = 32,
  parameter int unsigned IWIDTH       = 32,
  parameter int unsigned AWIDTH_MEM   = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 16
) (
  input  logic           ma_clk,
  input  logic           ma_rst,
  mem_arbiter_if.slave   bus
);

  localparam int unsigned BEW = DWIDTH / 8;
  localparam int unsigned WCW = $clog2(TIMEOUT);
  localparam int unsigned SCW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GNT_IF,
    S_GNT_DM,
    S_DONE_IF,
    S_DONE_DM
  } state_t;

  state_t                state;
  logic [WCW-1:0]        wait_cnt;
  logic [SCW-1:0]        starve_cnt;
  logic                  mem_req_q;
  logic                  mem_we_q;
  logic [AWIDTH_MEM-1:0] mem_addr_q;
  logic [DWIDTH-1:0]     mem_wdata_q;
  logic [BEW-1:0]        mem_be_q;
  logic [IWIDTH-1:0]     if_data_q;
  logic [DWIDTH-1:0]     dm_rdata_q;
  logic                  if_ack_q;
  logic                  dm_ack_q;
  logic                  err_q;

  logic                  timeout_hit;
  logic                  dm_wins;

  assign timeout_hit = (wait_cnt == WCW'(TIMEOUT - 1));
  // Data side wins ties unless fetch has already lost STARVE_LIMIT grants in a row.
  assign dm_wins = bus.ma_i_dm_req &&
                   !(bus.ma_i_if_req && (starve_cnt == SCW'(STARVE_LIMIT)));

  always_ff @(posedge ma_clk or negedge ma_rst) begin
    if (!ma_rst) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      starve_cnt  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_data_q   <= '0;
      dm_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if_ack_q <= 1'b0;
      dm_ack_q <= 1'b0;
      err_q    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!bus.ma_i_if_req) starve_cnt <= '0;
          if (bus.ma_i_ce && (bus.ma_i_if_req || bus.ma_i_dm_req)) begin
            mem_req_q <= 1'b1;
            wait_cnt  <= '0;
            if (dm_wins) begin
              state       <= S_GNT_DM;
              mem_we_q    <= bus.ma_i_dm_we;
              mem_addr_q  <= bus.ma_i_dm_addr;
              mem_wdata_q <= bus.ma_i_dm_wdata;
              mem_be_q    <= bus.ma_i_dm_be;
              if (bus.ma_i_if_req && (starve_cnt != SCW'(STARVE_LIMIT)))
                starve_cnt <= starve_cnt + SCW'(1);
            end else begin
              state       <= S_GNT_IF;
              mem_we_q    <= 1'b0;
              mem_addr_q  <= bus.ma_i_if_addr;
              mem_wdata_q <= '0;
              mem_be_q    <= '1;
              starve_cnt  <= '0;
            end
          end
        end
        S_GNT_IF, S_GNT_DM: begin
          if (bus.ma_i_mem_ack || timeout_hit) begin
            // An aborted access returns zero data and flags err alongside the ack.
            mem_req_q <= 1'b0;
            err_q     <= !bus.ma_i_mem_ack;
            if (state == S_GNT_IF) begin
              state     <= S_DONE_IF;
              if_ack_q  <= 1'b1;
              if_data_q <= bus.ma_i_mem_ack ? IWIDTH'(bus.ma_i_mem_rdata) : '0;
            end else begin
              state    <= S_DONE_DM;
              dm_ack_q <= 1'b1;
              if (!bus.ma_i_mem_ack)
                dm_rdata_q <= '0;
              else if (!mem_we_q)
                dm_rdata_q <= bus.ma_i_mem_rdata;
            end
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end
        S_DONE_IF, S_DONE_DM: begin
          state    <= S_IDLE;
          wait_cnt <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ma_o_mem_req   = mem_req_q;
  assign bus.ma_o_mem_we    = mem_we_q;
  assign bus.ma_o_mem_addr  = mem_addr_q;
  assign bus.ma_o_mem_wdata = mem_wdata_q;
  assign bus.ma_o_mem_be    = mem_be_q;
  assign bus.ma_o_if_data   = if_data_q;
  assign bus.ma_o_dm_rdata  = dm_rdata_q;
  assign bus.ma_o_if_ack    = if_ack_q;
  assign bus.ma_o_dm_ack    = dm_ack_q;
  assign bus.ma_o_err       = err_q;

  // Stalls follow the live request so the stage holds from the cycle it asks.
  assign bus.ma_o_stall_if = bus.ma_i_if_req & ~if_ack_q;
  assign bus.ma_o_stall_dm = bus.ma_i_dm_req & ~dm_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus hand sequences
// for starvation, timeout abort and mid-access reset.
module tb_mem_arbiter;

  logic ma_clk = 1'b0;
  logic ma_rst = 1'b0;
  always #5 ma_clk = ~ma_clk;

  mem_arbiter_if #(.DWIDTH(32), .IWIDTH(32), .AWIDTH_MEM(32)) bus ();

  mem_arbiter #(
    .DWIDTH(32), .IWIDTH(32), .AWIDTH_MEM(32), .STARVE_LIMIT(4), .TIMEOUT(16)
  ) dut (
    .ma_clk(ma_clk),
    .ma_rst(ma_rst),
    .bus   (bus)
  );

  typedef struct {
    logic        ce, if_req, dm_req, dm_we;
    logic [3:0]  dm_be;
    logic        mem_ack;
    logic [31:0] rdata;
    logic        e_req, e_we;
    logic [3:0]  e_be;
    logic [31:0] e_addr;
    logic        e_if_ack, e_dm_ack, e_err, e_st_if, e_st_dm;
    logic [31:0] e_if_data, e_dm_rdata;
  } vec_t;

  vec_t vecs[21];
  int   n_pass = 0;
  int   n_chk  = 0;
  logic order[10];
  logic exp_order[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge ma_clk);
    #1;
  endtask

  localparam logic [31:0] IFD = 32'h2008000A;
  localparam logic [31:0] LDD = 32'hCAFEF00D;

  initial begin
    int   g;
    int   cnt;
    logic prev;
    logic done;

    //          ce if dm we be    ack rdata         | req we be    addr    ifa dma err sif sdm if_data        dm_rdata
    vecs[0]  = '{1, 1, 0, 0, 4'hF, 0, 32'h0,        0, 0, 4'h0, 32'h00, 0, 0, 0, 1, 0, 32'h0,        32'h0};
    vecs[1]  = '{1, 1, 0, 0, 4'hF, 1, IFD,          1, 0, 4'hF, 32'h10, 0, 0, 0, 1, 0, 32'h0,        32'h0};
    vecs[2]  = '{1, 1, 0, 0, 4'hF, 0, 32'h0,        0, 0, 4'hF, 32'h10, 1, 0, 0, 0, 0, IFD,          32'h0};
    vecs[3]  = '{1, 0, 1, 1, 4'hF, 0, 32'h0,        0, 0, 4'hF, 32'h10, 0, 0, 0, 0, 1, IFD,          32'h0};
    vecs[4]  = '{1, 0, 1, 1, 4'hF, 0, 32'h0,        1, 1, 4'hF, 32'h40, 0, 0, 0, 0, 1, IFD,          32'h0};
    vecs[5]  = '{1, 0, 1, 1, 4'hF, 0, 32'h0,        1, 1, 4'hF, 32'h40, 0, 0, 0, 0, 1, IFD,          32'h0};
    vecs[6]  = '{1, 0, 1, 1, 4'hF, 0, 32'h0,        1, 1, 4'hF, 32'h40, 0, 0, 0, 0, 1, IFD,          32'h0};
    vecs[7]  = '{1, 0, 1, 1, 4'hF, 1, 32'h12345678, 1, 1, 4'hF, 32'h40, 0, 0, 0, 0, 1, IFD,          32'h0};
    vecs[8]  = '{1, 0, 1, 1, 4'hF, 0, 32'h0,        0, 1, 4'hF, 32'h40, 0, 1, 0, 0, 0, IFD,          32'h0};
    vecs[9]  = '{1, 0, 1, 0, 4'h3, 0, 32'h0,        0, 1, 4'hF, 32'h40, 0, 0, 0, 0, 1, IFD,          32'h0};
    vecs[10] = '{1, 0, 1, 0, 4'h3, 1, LDD,          1, 0, 4'h3, 32'h40, 0, 0, 0, 0, 1, IFD,          32'h0};
    vecs[11] = '{1, 0, 1, 0, 4'h3, 0, 32'h0,        0, 0, 4'h3, 32'h40, 0, 1, 0, 0, 0, IFD,          LDD};
    vecs[12] = '{0, 1, 1, 0, 4'h3, 0, 32'h0,        0, 0, 4'h3, 32'h40, 0, 0, 0, 1, 1, IFD,          LDD};
    vecs[13] = '{0, 1, 1, 0, 4'h3, 1, 32'h0,        0, 0, 4'h3, 32'h40, 0, 0, 0, 1, 1, IFD,          LDD};
    vecs[14] = '{1, 1, 1, 0, 4'h3, 0, 32'h0,        0, 0, 4'h3, 32'h40, 0, 0, 0, 1, 1, IFD,          LDD};
    vecs[15] = '{1, 1, 1, 0, 4'h3, 1, 32'h11111111, 1, 0, 4'h3, 32'h40, 0, 0, 0, 1, 1, IFD,          LDD};
    vecs[16] = '{1, 1, 1, 0, 4'h3, 0, 32'h0,        0, 0, 4'h3, 32'h40, 0, 1, 0, 1, 0, IFD,          32'h11111111};
    vecs[17] = '{1, 1, 0, 0, 4'h3, 0, 32'h0,        0, 0, 4'h3, 32'h40, 0, 0, 0, 1, 0, IFD,          32'h11111111};
    vecs[18] = '{1, 1, 0, 0, 4'h3, 1, 32'h22222222, 1, 0, 4'hF, 32'h10, 0, 0, 0, 1, 0, IFD,          32'h11111111};
    vecs[19] = '{1, 1, 0, 0, 4'h3, 0, 32'h0,        0, 0, 4'hF, 32'h10, 1, 0, 0, 0, 0, 32'h22222222, 32'h11111111};
    vecs[20] = '{1, 0, 0, 0, 4'h3, 0, 32'h0,        0, 0, 4'hF, 32'h10, 0, 0, 0, 0, 0, 32'h22222222, 32'h11111111};
    exp_order = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    bus.ma_i_ce        = 1'b0;
    bus.ma_i_if_req    = 1'b0;
    bus.ma_i_if_addr   = 32'h10;
    bus.ma_i_dm_req    = 1'b0;
    bus.ma_i_dm_we     = 1'b0;
    bus.ma_i_dm_addr   = 32'h40;
    bus.ma_i_dm_wdata  = 32'hDEADBEEF;
    bus.ma_i_dm_be     = 4'hF;
    bus.ma_i_mem_ack   = 1'b0;
    bus.ma_i_mem_rdata = 32'h0;

    #3;
    chk("rst_mem_req", 32'(bus.ma_o_mem_req), 32'h0);
    chk("rst_if_ack",  32'(bus.ma_o_if_ack),  32'h0);
    chk("rst_dm_ack",  32'(bus.ma_o_dm_ack),  32'h0);
    chk("rst_err",     32'(bus.ma_o_err),     32'h0);
    chk("rst_if_data", bus.ma_o_if_data,      32'h0);
    chk("rst_dm_rdata", bus.ma_o_dm_rdata,    32'h0);
    repeat (2) @(posedge ma_clk);
    @(negedge ma_clk);
    ma_rst = 1'b1;
    tick();

    // Cycle-accurate vectors: fetch, store, load, ce gating, fetch after data.
    for (int i = 0; i < 21; i++) begin
      bus.ma_i_ce        = vecs[i].ce;
      bus.ma_i_if_req    = vecs[i].if_req;
      bus.ma_i_dm_req    = vecs[i].dm_req;
      bus.ma_i_dm_we     = vecs[i].dm_we;
      bus.ma_i_dm_be     = vecs[i].dm_be;
      bus.ma_i_mem_ack   = vecs[i].mem_ack;
      bus.ma_i_mem_rdata = vecs[i].rdata;
      #1;
      chk($sformatf("v%0d_mem_req", i),  32'(bus.ma_o_mem_req),  32'(vecs[i].e_req));
      chk($sformatf("v%0d_mem_we", i),   32'(bus.ma_o_mem_we),   32'(vecs[i].e_we));
      chk($sformatf("v%0d_mem_be", i),   32'(bus.ma_o_mem_be),   32'(vecs[i].e_be));
      chk($sformatf("v%0d_mem_addr", i), bus.ma_o_mem_addr,      vecs[i].e_addr);
      chk($sformatf("v%0d_if_ack", i),   32'(bus.ma_o_if_ack),   32'(vecs[i].e_if_ack));
      chk($sformatf("v%0d_dm_ack", i),   32'(bus.ma_o_dm_ack),   32'(vecs[i].e_dm_ack));
      chk($sformatf("v%0d_err", i),      32'(bus.ma_o_err),      32'(vecs[i].e_err));
      chk($sformatf("v%0d_stall_if", i), 32'(bus.ma_o_stall_if), 32'(vecs[i].e_st_if));
      chk($sformatf("v%0d_stall_dm", i), 32'(bus.ma_o_stall_dm), 32'(vecs[i].e_st_dm));
      chk($sformatf("v%0d_if_data", i),  bus.ma_o_if_data,       vecs[i].e_if_data);
      chk($sformatf("v%0d_dm_rdata", i), bus.ma_o_dm_rdata,      vecs[i].e_dm_rdata);
      if (vecs[i].e_we)
        chk($sformatf("v%0d_mem_wdata", i), bus.ma_o_mem_wdata, 32'hDEADBEEF);
      tick();
    end

    // Starvation: both request continuously against a zero-wait memory.
    bus.ma_i_ce        = 1'b1;
    bus.ma_i_if_req    = 1'b1;
    bus.ma_i_dm_req    = 1'b1;
    bus.ma_i_dm_we     = 1'b0;
    bus.ma_i_mem_rdata = 32'hA5A5A5A5;
    g    = 0;
    prev = 1'b0;
    for (int cyc = 0; cyc < 200 && g < 10; cyc++) begin
      tick();
      bus.ma_i_mem_ack = bus.ma_o_mem_req;
      if (bus.ma_o_mem_req && !prev) begin
        order[g] = (bus.ma_o_mem_addr == 32'h40);
        g++;
      end
      prev = bus.ma_o_mem_req;
    end
    chk("starve_grant_count", 32'(g), 32'd10);
    for (int k = 0; k < 10; k++)
      chk($sformatf("starve_order%0d_dm", k), 32'(order[k]), 32'(exp_order[k]));

    bus.ma_i_if_req = 1'b0;
    bus.ma_i_dm_req = 1'b0;
    repeat (6) begin
      tick();
      bus.ma_i_mem_ack = bus.ma_o_mem_req;
    end
    bus.ma_i_mem_ack = 1'b0;
    chk("drain_idle", 32'(bus.ma_o_mem_req), 32'h0);
    chk("drain_dm_rdata", bus.ma_o_dm_rdata, 32'hA5A5A5A5);

    // Timeout: load to a memory that never acks; ce drops mid-access.
    bus.ma_i_dm_req = 1'b1;
    cnt  = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      tick();
      if (cyc == 5) bus.ma_i_ce = 1'b0;
      if (bus.ma_o_mem_req) cnt++;
      else if (cnt > 0) begin
        chk("to_req_cycles", 32'(cnt), 32'd16);
        chk("to_dm_ack", 32'(bus.ma_o_dm_ack), 32'h1);
        chk("to_err", 32'(bus.ma_o_err), 32'h1);
        chk("to_dm_rdata", bus.ma_o_dm_rdata, 32'h0);
        chk("to_stall_dm", 32'(bus.ma_o_stall_dm), 32'h0);
        bus.ma_i_dm_req = 1'b0;
        done = 1'b1;
        break;
      end
    end
    chk("to_done", 32'(done), 32'h1);
    bus.ma_i_dm_req = 1'b0;
    bus.ma_i_ce     = 1'b1;
    tick();
    chk("to_err_cleared", 32'(bus.ma_o_err), 32'h0);

    // Next request after the abort completes normally.
    bus.ma_i_if_req    = 1'b1;
    bus.ma_i_mem_rdata = 32'h0BADF00D;
    done = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      tick();
      bus.ma_i_mem_ack = bus.ma_o_mem_req;
      if (bus.ma_o_if_ack) begin
        chk("post_to_if_data", bus.ma_o_if_data, 32'h0BADF00D);
        chk("post_to_err", 32'(bus.ma_o_err), 32'h0);
        done = 1'b1;
        break;
      end
    end
    chk("post_to_done", 32'(done), 32'h1);
    bus.ma_i_if_req  = 1'b0;
    bus.ma_i_mem_ack = 1'b0;
    repeat (3) tick();

    // Reset during the second wait cycle of a load, then retry.
    bus.ma_i_dm_req = 1'b1;
    bus.ma_i_dm_we  = 1'b0;
    tick();
    chk("rl_wait1_req", 32'(bus.ma_o_mem_req), 32'h1);
    tick();
    chk("rl_wait2_req", 32'(bus.ma_o_mem_req), 32'h1);
    ma_rst = 1'b0;
    #1;
    chk("rl_req_dropped", 32'(bus.ma_o_mem_req), 32'h0);
    chk("rl_dm_ack",      32'(bus.ma_o_dm_ack),  32'h0);
    chk("rl_if_ack",      32'(bus.ma_o_if_ack),  32'h0);
    chk("rl_err",         32'(bus.ma_o_err),     32'h0);
    @(negedge ma_clk);
    ma_rst = 1'b1;
    bus.ma_i_mem_rdata = 32'h5A5A0001;
    done = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      tick();
      bus.ma_i_mem_ack = bus.ma_o_mem_req;
      if (bus.ma_o_dm_ack) begin
        chk("rl_retry_rdata", bus.ma_o_dm_rdata, 32'h5A5A0001);
        chk("rl_retry_err", 32'(bus.ma_o_err), 32'h0);
        done = 1'b1;
        break;
      end
    end
    chk("rl_retry_done", 32'(done), 32'h1);
    bus.ma_i_dm_req  = 1'b0;
    bus.ma_i_mem_ack = 1'b0;
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port unified memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the MIPS pipeline datapath.
- Grants one requester at a time and drives the shared memory handshake.
- Returns read data and an ack to the winning requester.
- Generates per-stage stall signals so the pipeline holds while its access is outstanding.
- Aborts hung memory accesses after a bounded timeout.

Parameters:
- DWIDTH, 32, data word width
- IWIDTH, 32, instruction width; must equal DWIDTH
- AWIDTH_MEM, 32, memory address width
- STARVE_LIMIT, 4, consecutive data-side grants while fetch waits before fetch is forced
- TIMEOUT, 16, wait cycles in a grant state before abort (≥2)

Ports:
- ma_clk  input  1  clock, rising edge
- ma_rst  input  1  asynchronous, active-low reset
- ma_i_ce  input  1  enable; low blocks new grants only
- ma_i_if_req  input  1  fetch request, held until ma_o_if_ack
- ma_i_if_addr  input  AWIDTH_MEM  fetch address
- ma_o_if_data  output  IWIDTH  fetched instruction, registered
- ma_o_if_ack  output  1  one-cycle fetch completion pulse
- ma_i_dm_req  input  1  data request, held until ma_o_dm_ack
- ma_i_dm_we  input  1  1=store, 0=load
- ma_i_dm_addr  input  AWIDTH_MEM  data address
- ma_i_dm_wdata  input  DWIDTH  store data
- ma_i_dm_be  input  DWIDTH/8  store byte enables
- ma_o_dm_rdata  output  DWIDTH  load data, registered
- ma_o_dm_ack  output  1  one-cycle data completion pulse
- ma_o_mem_req  output  1  memory request, held until ack or abort
- ma_o_mem_we  output  1  memory write enable
- ma_o_mem_addr  output  AWIDTH_MEM  memory address
- ma_o_mem_wdata  output  DWIDTH  memory write data
- ma_o_mem_be  output  DWIDTH/8  memory byte enables; all ones for fetch
- ma_i_mem_ack  input  1  memory completion
- ma_i_mem_rdata  input  DWIDTH  memory read data, valid with ack
- ma_o_err  output  1  one-cycle pulse, coincident with the ack of an aborted access
- ma_o_stall_if  output  1  ma_i_if_req & ~ma_o_if_ack, combinational
- ma_o_stall_dm  output  1  ma_i_dm_req & ~ma_o_dm_ack, combinational

Behaviour:
- Reset:
  - All registered outputs are 0; state is IDLE; starvation and timeout counters are 0.
  - Reset asserted mid-access drops ma_o_mem_req immediately, with no ack and no err.
- State IDLE, entered only when ma_i_ce=1:
  - dm_req alone → GNT_DM.
  - if_req alone → GNT_IF.
  - Both requesting → GNT_DM, unless starve_cnt==STARVE_LIMIT, then GNT_IF.
  - ma_i_ce=0 or no request → stay in IDLE.
- Grant-entry edge:
  - Latch address, we, wdata and be; fetch uses we=0 and be all ones.
  - Assert ma_o_mem_req; payload stays stable until exit.
- GNT_x with ma_i_mem_ack=1:
  - Next edge drops mem_req and goes to DONE_x.
  - Captures ma_i_mem_rdata into that requester's data register on reads; stores leave ma_o_dm_rdata unchanged.
  - Asserts that requester's ack for the DONE cycle.
- GNT_x with no ack:
  - wait_cnt increments.
  - When wait_cnt reaches TIMEOUT-1 and ack is still low, the next edge drops mem_req and enters DONE_x.
  - Requester data is forced to 0; ack and ma_o_err pulse together.
- DONE_x:
  - Exactly one cycle; grants nothing; next state IDLE.
  - Requester drops req by the end of this cycle.
  - wait_cnt clears.
- Latency: a request seen in IDLE at edge N with a zero-wait memory (ack during the first mem_req cycle) produces ack high in cycle N+2. Minimum access period is 3 cycles.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) on each GNT_DM entry while if_req=1.
  - Clears on GNT_IF entry, or in IDLE when if_req=0.
- ma_i_ce=0 during GNT/DONE: the access completes normally.
- ma_i_mem_ack while not in a GNT state is ignored.
- Requests changing while not in IDLE are ignored.

Test Plan:
- Fetch only, addr 0x10, memory acks on its first cycle with 0x2008000A → mem_req high 1 cycle, ma_o_if_data=0x2008000A, if_ack high at N+2, stall_if high cycles N..N+1.
- Store only, addr 0x40, wdata 0xDEADBEEF, be 4'b1111, memory waits 3 cycles → mem_we=1, payload stable 4 cycles, dm_ack single pulse, ma_o_dm_rdata unchanged.
- Both requesting continuously, STARVE_LIMIT=4 → grant order DM,DM,DM,DM,IF,DM…; fetch never waits more than 4 data grants.
- Memory never acks, TIMEOUT=16 → mem_req high exactly 16 cycles, then ack+err pulse same cycle, returned data 0, next request served normally.
- ma_i_ce=0 with both requests pending → no mem_req; raise ce → DM granted next edge.
- Reset pulled low on the 2nd wait cycle of a load → mem_req, acks, err all 0 immediately; after release the load re-requested completes normally.
